// File: rtl/pipe_skid_reg_if.sv
// Valid/ready stage-boundary bundle: upstream payload, downstream payload and flush.
// The master side feeds and drains the stage; the slave side is the stage itself.
interface pipe_skid_reg_if #(
   parameter int DATA_W = 96
);
   logic              in_valid;
   logic [DATA_W-1:0] in_data;
   logic              in_ready;
   logic              out_valid;
   logic [DATA_W-1:0] out_data;
   logic              out_ready;
   logic              flush;

   modport master (
      output in_valid, in_data, out_ready, flush,
      input  in_ready, out_valid, out_data
   );

   modport slave (
      input  in_valid, in_data, out_ready, flush,
      output in_ready, out_valid, out_data
   );
endinterface

// File: rtl/pipe_skid_reg.sv
// Pipeline stage register with a two-entry skid buffer, valid/ready handshake and flush.
// Optional stall/flush performance counters are built when PIPE_SKID_PERF_EN is defined.
module pipe_skid_reg #(
   parameter int                DATA_W       = 96,
   parameter logic [DATA_W-1:0] BUBBLE_VALUE = {64'd0, 32'h0000_0013},
   parameter int                CNT_W        = 16
) (
   input  logic                 clk,
   input  logic                 reset,
   pipe_skid_reg_if.slave       bus
`ifdef PIPE_SKID_PERF_EN
   ,
   output logic [CNT_W-1:0]     stall_cnt,
   output logic [CNT_W-1:0]     flush_cnt
`endif
);

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      FULL  = 2'd2
   } state_t;

   state_t            state_r;
   state_t            state_s;
   logic [DATA_W-1:0] main_r;
   logic [DATA_W-1:0] skid_r;
   logic              in_ready_s;
   logic              out_valid_s;
   logic [DATA_W-1:0] out_data_s;
   logic              accept_s;
   logic              drain_s;

   assign accept_s      = bus.in_valid && in_ready_s;
   assign drain_s       = out_valid_s && bus.out_ready;
   assign bus.in_ready  = in_ready_s;
   assign bus.out_valid = out_valid_s;
   assign bus.out_data  = out_data_s;

   // State register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_r <= EMPTY;
      end else begin
         state_r <= state_s;
      end
   end

   // Next-state logic; flush overrides any accept or drain
   always_comb begin
      state_s = state_r;
      if (bus.flush) begin
         state_s = EMPTY;
      end else begin
         case (state_r)
            EMPTY: begin
               if (accept_s) begin
                  state_s = ONE;
               end else begin
                  state_s = EMPTY;
               end
            end
            ONE: begin
               if (accept_s && !drain_s) begin
                  state_s = FULL;
               end else if (!accept_s && drain_s) begin
                  state_s = EMPTY;
               end else begin
                  state_s = ONE;
               end
            end
            FULL: begin
               if (drain_s) begin
                  state_s = ONE;
               end else begin
                  state_s = FULL;
               end
            end
            default: begin
               state_s = EMPTY;
            end
         endcase
      end
   end

   // Output decode; in_ready depends only on registered state and reset
   always_comb begin
      in_ready_s  = 1'b0;
      out_valid_s = 1'b0;
      out_data_s  = BUBBLE_VALUE;
      case (state_r)
         EMPTY: begin
            in_ready_s = reset;
         end
         ONE: begin
            in_ready_s  = reset;
            out_valid_s = 1'b1;
            out_data_s  = main_r;
         end
         FULL: begin
            out_valid_s = 1'b1;
            out_data_s  = main_r;
         end
         default: begin
            in_ready_s  = 1'b0;
            out_valid_s = 1'b0;
            out_data_s  = BUBBLE_VALUE;
         end
      endcase
   end

   // Payload storage: written only on accept or skid-to-main transfer, never cleared on drain
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         main_r <= BUBBLE_VALUE;
         skid_r <= BUBBLE_VALUE;
      end else if (!bus.flush) begin
         case (state_r)
            EMPTY: begin
               if (accept_s) main_r <= bus.in_data;
            end
            ONE: begin
               if (accept_s && drain_s) begin
                  main_r <= bus.in_data;
               end else if (accept_s) begin
                  skid_r <= bus.in_data;
               end
            end
            FULL: begin
               if (drain_s) main_r <= skid_r;
            end
            default: begin
               main_r <= main_r;
            end
         endcase
      end
   end

`ifdef PIPE_SKID_PERF_EN
   logic [CNT_W-1:0] stall_cnt_r;
   logic [CNT_W-1:0] flush_cnt_r;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      if (v == {CNT_W{1'b1}}) begin
         return v;
      end else begin
         return v + {{(CNT_W-1){1'b0}}, 1'b1};
      end
   endfunction

   // Saturating counters: stalled output cycles, and flushes that killed live entries
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         stall_cnt_r <= {CNT_W{1'b0}};
         flush_cnt_r <= {CNT_W{1'b0}};
      end else begin
         if (out_valid_s && !bus.out_ready) stall_cnt_r <= sat_inc(stall_cnt_r);
         if (bus.flush && (state_r != EMPTY)) flush_cnt_r <= sat_inc(flush_cnt_r);
      end
   end

   assign stall_cnt = stall_cnt_r;
   assign flush_cnt = flush_cnt_r;
`endif

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Scoreboard bench for pipe_skid_reg: directed scenarios plus random traffic,
// checked against a depth-2 FIFO reference model.
module tb_pipe_skid_reg;
   localparam int                DATA_W = 96;
   localparam logic [DATA_W-1:0] BUBBLE = {64'd0, 32'h0000_0013};
   localparam int                CNT_W  = 16;

   logic clk;
   logic reset;
   int   n_cmp;
   int   n_bad;

   logic [DATA_W-1:0] exp_q[$];
   logic              exp_in_ready;

   pipe_skid_reg_if #(.DATA_W(DATA_W)) intf ();

`ifdef PIPE_SKID_PERF_EN
   logic [CNT_W-1:0] stall_cnt;
   logic [CNT_W-1:0] flush_cnt;
   int               stall_exp;
   int               flush_exp;
`endif

   pipe_skid_reg #(.DATA_W(DATA_W), .BUBBLE_VALUE(BUBBLE), .CNT_W(CNT_W)) dut (
      .clk       (clk),
      .reset     (reset),
      .bus       (intf.slave)
`ifdef PIPE_SKID_PERF_EN
      ,
      .stall_cnt (stall_cnt),
      .flush_cnt (flush_cnt)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: accepted payloads queue up (at most 2 held); flush or reset empties it
   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         exp_q.delete();
      end else if (intf.flush) begin
         exp_q.delete();
      end else if (intf.in_valid && exp_in_ready) begin
         exp_q.push_back(intf.in_data);
      end
   end

   // Monitor: compare the presented output, pop what downstream consumes
   always @(negedge clk) begin
      logic exp_v;
      exp_v = (exp_q.size() > 0);
      chk("out_valid", {95'd0, intf.out_valid}, {95'd0, exp_v});
      chk("in_ready", {95'd0, intf.in_ready}, {95'd0, reset && (exp_q.size() < 2)});
      chk("out_data", intf.out_data, exp_v ? exp_q[0] : BUBBLE);
`ifdef PIPE_SKID_PERF_EN
      chk("stall_cnt", {{(DATA_W-CNT_W){1'b0}}, stall_cnt}, DATA_W'(stall_exp));
      chk("flush_cnt", {{(DATA_W-CNT_W){1'b0}}, flush_cnt}, DATA_W'(flush_exp));
      if (!reset) begin
         stall_exp = 0;
         flush_exp = 0;
      end else begin
         if (exp_v && !intf.out_ready && stall_exp < 65535) stall_exp++;
         if (intf.flush && exp_v && flush_exp < 65535) flush_exp++;
      end
`endif
      exp_in_ready = reset && (exp_q.size() < 2);
      if (exp_v && intf.out_ready && reset) void'(exp_q.pop_front());
   end

   task automatic cyc(input logic v, input logic [DATA_W-1:0] d, input logic r, input logic f);
      intf.in_valid  = v;
      intf.in_data   = d;
      intf.out_ready = r;
      intf.flush     = f;
      @(posedge clk);
      #1;
   endtask

   initial begin
      n_cmp = 0;
      n_bad = 0;
      exp_in_ready = 1'b0;
`ifdef PIPE_SKID_PERF_EN
      stall_exp = 0;
      flush_exp = 0;
`endif
      reset          = 1'b0;
      intf.in_valid  = 1'b0;
      intf.in_data   = '0;
      intf.out_ready = 1'b0;
      intf.flush     = 1'b0;
      #1;
      chk("rst_out_data", intf.out_data, BUBBLE);
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b1;
      #1;
      chk("rise_in_ready", {95'd0, intf.in_ready}, {95'd0, 1'b1});
      @(posedge clk);
      #1;

      // Streaming at full rate
      cyc(1'b1, 96'd1, 1'b1, 1'b0);
      cyc(1'b1, 96'd2, 1'b1, 1'b0);
      cyc(1'b1, 96'd3, 1'b1, 1'b0);
      repeat (2) cyc(1'b0, 96'd0, 1'b1, 1'b0);

      // Backpressure fills both entries, then releases in order
      cyc(1'b1, 96'd1, 1'b0, 1'b0);
      cyc(1'b1, 96'd2, 1'b0, 1'b0);
      cyc(1'b1, 96'd3, 1'b0, 1'b0);
      cyc(1'b1, 96'd3, 1'b1, 1'b0);
      cyc(1'b1, 96'd3, 1'b1, 1'b0);
      repeat (3) cyc(1'b0, 96'd0, 1'b1, 1'b0);

      // Flush while full discards held entries and the same-cycle offer
      cyc(1'b1, 96'd1, 1'b0, 1'b0);
      cyc(1'b1, 96'd2, 1'b0, 1'b0);
      cyc(1'b1, 96'd9, 1'b0, 1'b1);
      chk("flush_out_data", intf.out_data, BUBBLE);
      repeat (2) cyc(1'b0, 96'd0, 1'b1, 1'b0);

      // Async reset between edges while full
      cyc(1'b1, 96'd1, 1'b0, 1'b0);
      cyc(1'b1, 96'd2, 1'b0, 1'b0);
      intf.in_valid = 1'b0;
      #1;
      reset = 1'b0;
      #1;
      chk("async_out_valid", {95'd0, intf.out_valid}, 96'd0);
      chk("async_in_ready", {95'd0, intf.in_ready}, 96'd0);
      chk("async_out_data", intf.out_data, BUBBLE);
      @(posedge clk);
      #1;
      reset = 1'b1;
      cyc(1'b1, 96'd5, 1'b1, 1'b0);
      chk("post_rst_data", intf.out_data, 96'd5);
      repeat (2) cyc(1'b0, 96'd0, 1'b1, 1'b0);

`ifdef PIPE_SKID_PERF_EN
      // Four stalled cycles, then a flush with one live entry
      cyc(1'b1, 96'd7, 1'b0, 1'b0);
      repeat (4) cyc(1'b0, 96'd0, 1'b0, 1'b0);
      cyc(1'b0, 96'd0, 1'b0, 1'b1);
`endif

      // Random traffic with occasional flushes
      for (int i = 0; i < 600; i++) begin
         cyc(1'($urandom_range(0, 3) != 0), {$urandom, $urandom, $urandom},
             1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 15) == 0));
      end
      repeat (4) cyc(1'b0, 96'd0, 1'b1, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/pipe_skid_reg.md
# pipe_skid_reg

Parametrised pipeline stage register with a valid/ready handshake and a two-entry skid buffer. It replaces the fixed IF/ID latch: busywait stalls become backpressure, the payload width is generic, and the stage gains a synchronous flush that inserts a bubble. One instance sits at each stage boundary (IF/ID, ID/EX, EX/MEM, MEM/WB), and `DATA_W` is sized to the fields that boundary carries.

## Interface
- `DATA_W`, 96: payload width in bits (for IF/ID: pc_plus_4, pc, instruction).
- `BUBBLE_VALUE`, {64'd0, 32'h0000_0013}: value driven on `out_data` whenever `out_valid` is 0; default is zero PCs plus the RV32 NOP `addi x0,x0,0`.
- `CNT_W`, 16: width of the performance counters (only with `PIPE_SKID_PERF_EN`).

Ports:
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  upstream has a payload.
- `in_data`  in  DATA_W  upstream payload.
- `in_ready`  out  1  stage can accept this cycle.
- `out_valid`  out  1  `out_data` holds a live payload.
- `out_data`  out  DATA_W  payload to the next stage.
- `out_ready`  in  1  downstream consumes this cycle.
- `flush`  in  1  synchronous kill of all held entries.
- `stall_cnt`  out  CNT_W  (`PIPE_SKID_PERF_EN` only) cycles with `out_valid && !out_ready`.
- `flush_cnt`  out  CNT_W  (`PIPE_SKID_PERF_EN` only) flushes that discarded at least one valid entry.

## Operation
- Storage: `main` entry (drives the output) and `skid` entry; each has a data register and a valid bit.
- States: EMPTY (none valid), ONE (main valid), FULL (main and skid valid). The skid entry is never valid while main is empty.
- `accept = in_valid && in_ready`; `drain = out_valid && out_ready`.
- `in_ready = (state != FULL)`. It is a pure function of registered state, with no combinational path from `out_ready`. It is forced to 0 while `reset` is low.
- `out_valid = main.valid`; `out_data = main.valid ? main.data : BUBBLE_VALUE`.
- Transitions without flush:
  - EMPTY: accept → ONE (`main` ← `in_data`).
  - ONE: accept and drain → ONE (`main` ← `in_data`).
  - ONE: accept only → FULL (`skid` ← `in_data`).
  - ONE: drain only → EMPTY.
  - FULL: drain → ONE (`main` ← `skid`). Accept cannot occur in FULL.
  - Any state with neither accept nor drain holds.
- Ordering is strictly FIFO. No payload is duplicated or dropped except by flush.
- `flush` has priority over everything. Next state is EMPTY, and a same-cycle `in_data` is discarded even if `in_ready` was 1. A drain in the flush cycle still counts for the downstream stage.
- Data registers are written only on accept or on skid→main transfer. They are not cleared on drain.

## Timing
- Latency: `in_data` accepted at edge N is visible on `out_data` after edge N when EMPTY, or when ONE with a same-cycle drain.
- Throughput: 1 payload/cycle when `out_ready` stays high.
- Backpressure: after `out_ready` drops, the stage absorbs at most 2 payloads, then `in_ready` = 0 from the following cycle.
- Reset (async, on `reset` low): state EMPTY, both valid bits 0, data registers = `BUBBLE_VALUE`, `out_valid` = 0, `out_data` = `BUBBLE_VALUE`, `in_ready` = 0, counters = 0.
  - `in_ready` rises when `reset` deasserts, combinationally from the EMPTY state.
  - Reset mid-transfer drops all held entries.
- Simultaneous flush and reset: reset wins.
- Counters saturate at all-ones and never wrap.

## Configuration
- `PIPE_SKID_PERF_EN`:
  - Defined: `stall_cnt`/`flush_cnt` ports and logic exist.
  - Undefined: ports and registers are absent, and the handshake behaviour is identical.

## Test plan
- Streaming: `out_ready`=1, inject A=1, B=2, C=3 in consecutive cycles → `out_data` payloads 1, 2, 3 on the three cycles after each accept, `in_ready` always 1.
- Backpressure: `out_ready`=0, offer 1, 2, 3 → 1 and 2 accepted, `in_ready`=0 while 3 is presented. Raise `out_ready` → outputs 1, 2, 3 in order with no gap after the first.
- Flush while FULL: hold 1, 2, assert `flush` with `in_valid`=1, `in_data`=9 → next cycle `out_valid`=0, `out_data`=`BUBBLE_VALUE`, `in_ready`=1; 9 never appears.
- Async reset mid-stream: pull `reset` low between edges while FULL → `out_valid` 0 and `in_ready` 0 immediately. After release, a fresh payload 5 emerges with 1-cycle latency.
- Perf (with macro): 4 cycles of `out_valid`=1 and `out_ready`=0, then flush with one valid entry → `stall_cnt`=4, `flush_cnt`=1. With `CNT_W`=2 and 6 stall cycles → `stall_cnt`=3.
